// File: rtl/traffic_uart_pkg.sv
// Shared definitions for the traffic-light UART blocks: ASCII codes, TX FSM states,
// the default baud divider shared with uart_rx, and the status-to-character encoder.
package traffic_uart_pkg;

    localparam int CLKS_PER_BIT_DEFAULT = 10;

    localparam logic [7:0] CH_R  = 8'h52;
    localparam logic [7:0] CH_Y  = 8'h59;
    localparam logic [7:0] CH_G  = 8'h47;
    localparam logic [7:0] CH_X  = 8'h58;
    localparam logic [7:0] CH_CR = 8'h0D;
    localparam logic [7:0] CH_LF = 8'h0A;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } tx_state_e;

    // Exactly one lamp lit maps to its letter; anything else is reported as illegal.
    function automatic logic [7:0] encode_status(input logic [2:0] ryg);
        logic [7:0] ch;
        case (ryg)
            3'b100:  ch = CH_R;
            3'b010:  ch = CH_Y;
            3'b001:  ch = CH_G;
            default: ch = CH_X;
        endcase
        return ch;
    endfunction

endpackage

// File: rtl/uart_tx_core.sv
// 8N1 UART transmitter core. A start request seen at the end of a stop bit chains the
// next frame with no idle gap, keeping busy high across the chained frames.
module uart_tx_core
    import traffic_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data_in,
    output logic       tx,
    output logic       busy,
    output logic       done
);

    tx_state_e        state_r, state_s;
    logic [CNT_W-1:0] baud_cnt_r;
    logic [2:0]       bit_cnt_r;
    logic [7:0]       shift_r;
    logic             tx_r, busy_r, done_r;
    logic             bit_end_s, load_s;

    assign bit_end_s = (baud_cnt_r == CNT_W'(CLKS_PER_BIT - 1));

    // Next-state decode and frame-load request.
    always_comb begin
        state_s = state_r;
        load_s  = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_s = ST_START;
                    load_s  = 1'b1;
                end else begin
                    state_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (bit_end_s) state_s = ST_DATA;
                else           state_s = ST_START;
            end
            ST_DATA: begin
                if (bit_end_s && (bit_cnt_r == 3'd7)) state_s = ST_STOP;
                else                                  state_s = ST_DATA;
            end
            ST_STOP: begin
                if (bit_end_s && start) begin
                    state_s = ST_START;
                    load_s  = 1'b1;
                end else if (bit_end_s) begin
                    state_s = ST_IDLE;
                end else begin
                    state_s = ST_STOP;
                end
            end
            default: state_s = ST_IDLE;
        endcase
    end

    // State register, baud/bit counters, shift register and registered line outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            baud_cnt_r <= '0;
            bit_cnt_r  <= 3'd0;
            shift_r    <= 8'h00;
            tx_r       <= 1'b1;
            busy_r     <= 1'b0;
            done_r     <= 1'b0;
        end else begin
            state_r <= state_s;
            done_r  <= (state_r == ST_STOP) && bit_end_s;
            if ((state_r == ST_IDLE) || bit_end_s) baud_cnt_r <= '0;
            else                                   baud_cnt_r <= baud_cnt_r + CNT_W'(1);
            if (load_s) begin
                shift_r <= data_in;
                tx_r    <= 1'b0;
                busy_r  <= 1'b1;
            end else begin
                case (state_r)
                    ST_START: if (bit_end_s) tx_r <= shift_r[0];
                    ST_DATA: begin
                        if (bit_end_s && (bit_cnt_r == 3'd7)) begin
                            bit_cnt_r <= 3'd0;
                            tx_r      <= 1'b1;
                        end else if (bit_end_s) begin
                            bit_cnt_r <= bit_cnt_r + 3'd1;
                            shift_r   <= {1'b0, shift_r[7:1]};
                            tx_r      <= shift_r[1];
                        end
                    end
                    ST_STOP: if (bit_end_s) busy_r <= 1'b0;
                    default: tx_r <= 1'b1;
                endcase
            end
        end
    end

    assign tx   = tx_r;
    assign busy = busy_r;
    assign done = done_r;

endmodule

// File: rtl/light_status_uart_tx.sv
// Reports each traffic-light status change as one ASCII byte over UART, with a 1-deep
// pending buffer. Define STATUS_CRLF_EN to follow every status byte with CR LF.
module light_status_uart_tx
    import traffic_uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int CNT_W        = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic red_light,
    input  logic yellow_light,
    input  logic green_light,
    input  logic report_now,
    output logic tx,
    output logic tx_busy,
    output logic dropped
);

`ifdef STATUS_CRLF_EN
    localparam logic [1:0] SUFFIX_FIRST = 2'd1;
`else
    localparam logic [1:0] SUFFIX_FIRST = 2'd0;
`endif

    logic [2:0] lights_s, status_q_r;
    logic [7:0] pending_code_r, data_s;
    logic       pending_valid_r, dropped_r;
    logic [1:0] suffix_idx_r;
    logic       event_s, consume_s, start_s;
    logic       core_tx_s, core_busy_s, core_done_s;

    assign lights_s  = {red_light, yellow_light, green_light};
    assign event_s   = (lights_s != status_q_r) || report_now;
    assign consume_s = pending_valid_r && !core_busy_s;

    // While a frame is in flight only suffix characters may chain; otherwise the pending code starts.
    always_comb begin
        start_s = 1'b0;
        data_s  = pending_code_r;
        if (core_busy_s) begin
            start_s = (suffix_idx_r != 2'd0);
            data_s  = (suffix_idx_r == 2'd1) ? CH_CR : CH_LF;
        end else begin
            start_s = pending_valid_r;
            data_s  = pending_code_r;
        end
    end

    // Change detection, pending buffer, overwrite pulse and suffix sequencing.
    always_ff @(posedge clk) begin
        if (rst) begin
            status_q_r      <= 3'b000;
            pending_code_r  <= 8'h00;
            pending_valid_r <= 1'b0;
            dropped_r       <= 1'b0;
            suffix_idx_r    <= 2'd0;
        end else begin
            status_q_r <= lights_s;
            if (event_s) begin
                pending_code_r  <= encode_status(lights_s);
                pending_valid_r <= 1'b1;
                dropped_r       <= pending_valid_r && !consume_s;
            end else begin
                dropped_r <= 1'b0;
                if (consume_s) pending_valid_r <= 1'b0;
            end
            if (consume_s) begin
                suffix_idx_r <= SUFFIX_FIRST;
            end else if (core_done_s) begin
                case (suffix_idx_r)
                    2'd1:    suffix_idx_r <= 2'd2;
                    2'd2:    suffix_idx_r <= 2'd0;
                    default: suffix_idx_r <= suffix_idx_r;
                endcase
            end
        end
    end

    uart_tx_core #(
        .CLKS_PER_BIT(CLKS_PER_BIT),
        .CNT_W       (CNT_W)
    ) u_core (
        .clk    (clk),
        .rst    (rst),
        .start  (start_s),
        .data_in(data_s),
        .tx     (core_tx_s),
        .busy   (core_busy_s),
        .done   (core_done_s)
    );

    assign tx      = core_tx_s;
    assign tx_busy = core_busy_s;
    assign dropped = dropped_r;

endmodule

// File: doc/light_status_uart_tx.md
Name: light_status_uart_tx

Overview:
Downstream companion to the UART-driven traffic light controller. Monitors the controller's red/yellow/green outputs and reports each change as one ASCII byte over a UART TX line: 'R', 'Y', 'G', or 'X' for an illegal combination. This closes the loop so the host can confirm that each command took effect. Holds a 1-deep pending buffer so that a change arriving mid-frame is not lost.

Parameters:
CLKS_PER_BIT, 10, clk cycles per UART bit (must be >= 2); frame = 10*CLKS_PER_BIT cycles
CNT_W, 16, width of baud counter; must hold CLKS_PER_BIT-1

Ports:
clk  input  1  system clock; single clock domain
rst  input  1  synchronous, active-high reset
red_light  input  1  controller red output
yellow_light  input  1  controller yellow output
green_light  input  1  controller green output
report_now  input  1  1-cycle pulse; forces a report of the current status even without a change
tx  output  1  UART serial out, idle high, 8N1, LSB first
tx_busy  output  1  high from start bit through end of stop bit
dropped  output  1  1-cycle pulse when an unsent pending code is overwritten

Behaviour:
- Reset (rst=1 at a clk edge): tx=1, tx_busy=0, dropped=0, FSM=IDLE, pending_valid=0, status_q=3'b000, baud/bit counters=0.
- Encoding of {r,y,g}: 100->0x52 'R'; 010->0x59 'Y'; 001->0x47 'G'; any other value (000, or multiple bits set)->0x58 'X'.
- Change detect: each edge, status_q <= {r,y,g}. If {r,y,g} != status_q, or report_now=1: pending_code <= encode({r,y,g}) and pending_valid <= 1.
- The first edge after reset with red=1 therefore counts as a change and yields 'R'.
- Overwrite: if pending_valid=1 and is not being consumed on the same edge, a new event replaces pending_code and dropped pulses for 1 cycle. Newest code wins.
- FSM states: IDLE, START, DATA, STOP.
- IDLE: tx=1. If pending_valid, then on the next edge: load shift register from pending_code, clear pending_valid, go to START, tx<=0, tx_busy<=1.
- Same-edge consume and new event: the new event sets pending_valid=1 with the new code. No dropped pulse is raised.
- START: hold for CLKS_PER_BIT cycles, then DATA.
- DATA: 8 bits, LSB first, each held CLKS_PER_BIT cycles. The bit counter wraps 7->0 on transition to STOP.
- STOP: tx=1 for CLKS_PER_BIT cycles, then IDLE with tx_busy<=0. If pending_valid is set at that point, the next START begins on the following edge; the minimum inter-frame idle is 1 cycle.
- Latency: input change sampled at edge N -> tx falls after edge N+1 (when IDLE).
- Reset mid-frame: frame is abandoned immediately, tx returns high next edge, pending discarded; no partial stop bit required.
- report_now asserted together with a change produces a single event, not two.

Optional Feature:
STATUS_CRLF_EN. When defined, each status byte is followed back-to-back by 0x0D then 0x0A. These trailing frames go through the same FSM, with a 2-bit suffix index. tx_busy stays high across all three frames. A pending event waits until after 0x0A. When not defined, only the single status byte is sent.

Decomposition:
- Shared package/include traffic_uart_pkg holds:
  - ASCII constants CH_R, CH_Y, CH_G, CH_X, CH_CR, CH_LF
  - FSM state encodings
  - a default CLKS_PER_BIT shared with uart_rx
- One natural sub-module, uart_tx_core: baud counter, bit counter and shift register, with a start/data_in/busy/done interface.
- Change detect, encoding and the pending buffer stay in the top.

Test Plan (CLKS_PER_BIT=10):
1. Reset release with r,y,g=1,0,0 -> tx low 2 edges after release; bits over 100 cycles each 10 clk: 0 | 0,1,0,0,1,0,1,0 | 1 ('R'=0x52); tx_busy high exactly 100 cycles.
2. Switch to 0,1,0 while idle -> 'Y' (0x59) frame; then 0,0,1 -> 'G' (0x47); bench decodes the tx line and matches.
3. Drive 1,1,0 -> 'X' (0x58); drive 0,0,0 -> second 'X' frame.
4. During an 'R' frame, change to Y then G before the stop bit -> dropped pulses once; after 'R', exactly one 'G' frame follows with 1 idle cycle between.
5. Assert rst at DATA bit 3 -> tx=1 next edge, tx_busy=0, no further frame until the next input change.
6. report_now pulse with lights stable at G -> one 'G' frame; with STATUS_CRLF_EN defined -> 0x47, 0x0D, 0x0A back-to-back, tx_busy high for 300 cycles.
